// File: rtl/mem_model_pkg.sv
// Shared encodings and defaults for the latency memory model.
package mem_model_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  localparam logic [31:0] DEF_STDOUT_ADDR = 32'hf000_0000;
  localparam logic [31:0] DEF_EXIT_ADDR   = 32'hff00_0000;

endpackage

// File: rtl/mem_lane_steer.sv
// Maps a range-relative byte offset and access size to per-lane byte indices.
// Lane i carries data[8*i+7:8*i]; the range check uses 33-bit arithmetic so
// accesses running past the top of the 32-bit space never wrap into range.
module mem_lane_steer
  import mem_model_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 65536,
  parameter int unsigned AW          = $clog2(DEPTH_BYTES)
) (
  input  logic [1:0]          size,
  input  logic [31:0]         offset,
  output logic [3:0][AW-1:0]  lane_idx,
  output logic [3:0]          lane_en,
  output logic                in_range
);

  localparam logic [32:0] DEPTH_X = 33'(DEPTH_BYTES);

  logic [31:0] half_base;
  logic [31:0] byte_base;

  // Lane steering and range check; byte mapping is the default (covers SIZE=11).
  always_comb begin
    half_base = {offset[31:2], 2'b10} - {30'b0, offset[1:0]};
    byte_base = {offset[31:2], 2'b11} - {30'b0, offset[1:0]};
    lane_idx    = '0;
    lane_idx[0] = AW'(byte_base);
    lane_en     = 4'b0001;
    in_range    = {1'b0, byte_base} < DEPTH_X;
    case (size)
      SZ_WORD: begin
        for (int unsigned i = 0; i < 4; i++) begin
          lane_idx[i] = AW'(offset + (32'd3 - 32'(i)));
        end
        lane_en  = '1;
        in_range = ({1'b0, offset} + 33'd3) < DEPTH_X;
      end
      SZ_HALF: begin
        lane_idx[1] = AW'(half_base);
        lane_idx[0] = AW'(half_base + 32'd1);
        lane_en     = 4'b0011;
        in_range    = ({1'b0, half_base} + 33'd1) < DEPTH_X;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/latency_mem_model.sv
// Behavioural memory with a fixed request-to-ack latency, a console port
// and an exit port. Acks, read data and strobes are decoded from the ACK state.
module latency_mem_model
  import mem_model_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0800_0000,
  parameter int unsigned DEPTH_BYTES = 65536,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] STDOUT_ADDR = DEF_STDOUT_ADDR,
  parameter logic [31:0] EXIT_ADDR   = DEF_EXIT_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  input  logic [31:0] DAD,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ACKD_n,
  output logic        char_valid,
  output logic [7:0]  char_data,
  output logic        exit_pulse,
  output logic        halted,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [31:0] addr_q, wdata_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        halted_q;

  logic [7:0]  mem [DEPTH_BYTES];

  logic [3:0][AW-1:0] lane_idx;
  logic [3:0]         lane_en;
  logic               in_range;
  logic               accept, is_ack, is_port, mem_we, load_hit;

  assign accept = (state == IDLE) && MREQ && !halted_q;
  assign halted = halted_q;

  mem_lane_steer #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .AW          (AW)
  ) u_steer (
    .size     (size_q),
    .offset   (addr_q - BASE_ADDR),
    .lane_idx (lane_idx),
    .lane_en  (lane_en),
    .in_range (in_range)
  );

  // State, latency counter, request latch and sticky halt flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        addr_q  <= DAD;
        wdata_q <= wdata;
        write_q <= WRITE;
        size_q  <= SIZE;
      end
      if (exit_pulse) halted_q <= 1'b1;
    end
  end

  // Next-state: count down in WAIT, abort if the request is withdrawn.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = WAIT;
          cnt_next   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (!MREQ) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == '0) begin
          state_next = ACK;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ack-cycle outputs: port strobes, range error, load data.
  always_comb begin
    is_ack     = (state == ACK);
    is_port    = (addr_q == STDOUT_ADDR) || (addr_q == EXIT_ADDR);
    ACKD_n     = !is_ack;
    char_valid = is_ack && write_q && (addr_q == STDOUT_ADDR);
    char_data  = char_valid ? wdata_q[7:0] : '0;
    exit_pulse = is_ack && write_q && (addr_q == EXIT_ADDR);
    err        = is_ack && !is_port && !in_range;
    mem_we     = is_ack && write_q && !is_port && in_range && !rst;
    load_hit   = is_ack && !write_q && !is_port && in_range;
    rdata      = '0;
    if (load_hit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_en[i]) rdata[8*i +: 8] = mem[lane_idx[i]];
      end
    end
  end

  // Byte-array storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[lane_idx[i]] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_latency_mem_model.sv
// Scoreboard bench: the driver pushes expected responses computed from a
// byte-array reference model; a negedge monitor pops and compares on each ack.
module tb_latency_mem_model;
  import mem_model_pkg::*;

  localparam logic [31:0] BASE   = 32'h0800_0000;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned LAT    = 3;
  localparam logic [31:0] STDOUT = 32'hf000_0000;
  localparam logic [31:0] EXITA  = 32'hff00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MREQ = 1'b0, WRITE = 1'b0;
  logic [1:0]  SIZE = '0;
  logic [31:0] DAD = '0, wdata = '0;
  logic [31:0] rdata;
  logic        ACKD_n, char_valid, exit_pulse, halted, err;
  logic [7:0]  char_data;

  latency_mem_model #(
    .BASE_ADDR   (BASE),
    .DEPTH_BYTES (DEPTH),
    .LATENCY     (LAT),
    .STDOUT_ADDR (STDOUT),
    .EXIT_ADDR   (EXITA)
  ) dut (
    .clk (clk), .rst (rst), .MREQ (MREQ), .WRITE (WRITE), .SIZE (SIZE),
    .DAD (DAD), .wdata (wdata), .rdata (rdata), .ACKD_n (ACKD_n),
    .char_valid (char_valid), .char_data (char_data),
    .exit_pulse (exit_pulse), .halted (halted), .err (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        cv;
    logic [7:0]  cd;
    logic        ex;
    int unsigned ack_cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [7:0]  ref_mem [DEPTH];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0, n_bad = 0, n_acks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: which memory bytes an access touches, most significant first.
  task automatic model_req(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, output exp_t e);
    logic [31:0]       a, p;
    longint unsigned   pos [4];
    int                n;
    bit                ok;
    e.rdata = '0; e.err = 1'b0; e.cv = 1'b0; e.cd = '0; e.ex = 1'b0; e.ack_cyc = 0;
    if (addr == STDOUT || addr == EXITA) begin
      if (wr && addr == STDOUT) begin e.cv = 1'b1; e.cd = wd[7:0]; end
      if (wr && addr == EXITA) e.ex = 1'b1;
      return;
    end
    a = addr - BASE;
    if (sz == SZ_WORD) begin
      n = 4;
      for (int k = 0; k < 4; k++) pos[k] = longint'(a) + longint'(k);
    end else if (sz == SZ_HALF) begin
      n = 2;
      p = {a[31:2], 2'b10} - 32'(a[1:0]);
      pos[0] = longint'(p);
      pos[1] = longint'(p) + 1;
    end else begin
      n = 1;
      p = {a[31:2], 2'b11} - 32'(a[1:0]);
      pos[0] = longint'(p);
    end
    ok = 1'b1;
    for (int k = 0; k < n; k++) if (pos[k] >= longint'(DEPTH)) ok = 1'b0;
    if (!ok) begin e.err = 1'b1; return; end
    for (int k = 0; k < n; k++) begin
      if (wr) ref_mem[int'(pos[k])] = wd[8*(n-1-k) +: 8];
      else    e.rdata[8*(n-1-k) +: 8] = ref_mem[int'(pos[k])];
    end
  endtask

  // Monitor: compare every ack against the scoreboard; quiet cycles must be all-zero.
  always @(negedge clk) begin
    if (!rst) begin
      if (ACKD_n === 1'b0) begin
        n_acks++;
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_ack: got ack at cycle %0d, expected none", cyc);
        end else begin
          mon_e = sbq.pop_front();
          check("ack_cycle", cyc, mon_e.ack_cyc);
          check("rdata", rdata, mon_e.rdata);
          check("err", {31'b0, err}, {31'b0, mon_e.err});
          check("char_valid", {31'b0, char_valid}, {31'b0, mon_e.cv});
          check("char_data", {24'b0, char_data}, {24'b0, mon_e.cd});
          check("exit_pulse", {31'b0, exit_pulse}, {31'b0, mon_e.ex});
        end
      end else begin
        check("idle_rdata", rdata, 32'h0);
        check("idle_strobes", {28'b0, char_valid, exit_pulse, err, |char_data}, 32'h0);
      end
    end
  end

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd);
    exp_t e;
    int   k;
    @(negedge clk);
    model_req(wr, sz, addr, wd, e);
    e.ack_cyc = cyc + 1 + LAT;
    sbq.push_back(e);
    MREQ = 1'b1; WRITE = wr; SIZE = sz; DAD = addr; wdata = wd;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ACKD_n !== 1'b0 && k < int'(LAT) + 8);
    MREQ = 1'b0;
    if (ACKD_n !== 1'b0) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_timeout: got no ack after %0d cycles, expected ack after %0d", k, LAT);
      if (sbq.size() > 0) void'(sbq.pop_back());
    end
  endtask

  // Request that is withdrawn (or reset) after 'hold' WAIT cycles; no ack expected.
  task automatic do_abort(input logic [31:0] addr, input logic [31:0] wd, input int hold,
                          input bit use_rst);
    @(negedge clk);
    MREQ = 1'b1; WRITE = 1'b1; SIZE = SZ_WORD; DAD = addr; wdata = wd;
    repeat (hold) @(negedge clk);
    MREQ = 1'b0;
    if (use_rst) begin
      rst = 1'b1;
      @(negedge clk);
      check("rst_ackd_n", {31'b0, ACKD_n}, 32'h1);
      check("rst_rdata", rdata, 32'h0);
      check("rst_outs", {27'b0, char_valid, exit_pulse, halted, err, |char_data}, 32'h0);
      rst = 1'b0;
    end
    repeat (LAT + 2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] addr;
    logic [1:0]  sz;
    int unsigned acks_before;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_ackd_n", {31'b0, ACKD_n}, 32'h1);
    check("reset_rdata", rdata, 32'h0);
    check("reset_outs", {27'b0, char_valid, exit_pulse, halted, err, |char_data}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < int'(DEPTH) / 4; i++) do_req(1'b1, SZ_WORD, BASE + 32'(4 * i), 32'h0);

    do_req(1'b1, SZ_WORD, BASE, 32'h1122_3344);
    do_req(1'b0, SZ_WORD, BASE, 32'h0);
    do_req(1'b1, SZ_WORD, BASE, 32'h0);
    do_req(1'b1, SZ_BYTE, BASE + 32'd1, 32'h0000_00AB);
    do_req(1'b0, SZ_WORD, BASE, 32'h0);
    do_req(1'b0, SZ_HALF, BASE + 32'd1, 32'h0);

    do_abort(BASE + 32'd8, 32'hDEAD_BEEF, 2, 1'b0);
    do_req(1'b0, SZ_WORD, BASE + 32'd8, 32'h0);

    do_req(1'b1, SZ_BYTE, STDOUT, 32'h0000_0041);
    do_req(1'b0, SZ_WORD, STDOUT, 32'h0);
    do_req(1'b0, SZ_WORD, EXITA, 32'h0);

    do_req(1'b0, SZ_WORD, BASE + DEPTH - 32'd2, 32'h0);
    do_req(1'b1, SZ_WORD, BASE + DEPTH - 32'd4, 32'hCAFE_F00D);
    do_req(1'b0, SZ_WORD, BASE + DEPTH - 32'd4, 32'h0);
    do_req(1'b0, SZ_WORD, BASE - 32'd1, 32'h0);
    do_req(1'b0, SZ_HALF, BASE + 32'd3, 32'h0);
    do_req(1'b0, SZ_BYTE, BASE + DEPTH, 32'h0);
    do_req(1'b1, 2'b11, BASE + 32'd6, 32'h0000_005A);
    do_req(1'b0, SZ_WORD, BASE + 32'd4, 32'h0);

    do_abort(BASE + 32'd12, 32'h55AA_55AA, 1, 1'b1);
    do_req(1'b0, SZ_WORD, BASE + 32'd12, 32'h0);

    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: addr = BASE + ($urandom % DEPTH);
        6:       addr = BASE + DEPTH - 32'd4 + ($urandom % 8);
        7:       addr = BASE - 32'd4 + ($urandom % 4);
        8:       addr = STDOUT;
        default: addr = BASE + (($urandom % DEPTH) & ~32'd3);
      endcase
      do_req(1'($urandom_range(0, 1)), sz, addr, $urandom);
    end

    do_req(1'b1, SZ_WORD, EXITA, 32'h0000_0001);
    @(negedge clk);
    check("halted_set", {31'b0, halted}, 32'h1);
    acks_before = n_acks;
    MREQ = 1'b1; WRITE = 1'b0; SIZE = SZ_WORD; DAD = BASE;
    repeat (3 * LAT + 6) @(negedge clk);
    MREQ = 1'b0;
    check("halted_no_ack", n_acks - acks_before, 32'h0);
    check("halted_sticky", {31'b0, halted}, 32'h1);

    rst = 1'b1;
    @(negedge clk);
    check("rst_clears_halted", {31'b0, halted}, 32'h0);
    rst = 1'b0;
    do_req(1'b0, SZ_WORD, BASE + DEPTH - 32'd4, 32'h0);

    repeat (4) @(negedge clk);
    if (sbq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
